// File: rtl/mem_responder_pkg.sv
// Shared constants for the wait-state memory responder: state encodings,
// default wait-state count and counter sizing.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

  // Wait-state count as loaded into the down-counter (legal range 0..15).
  function automatic logic [CNT_W-1:0] wait_load(input int cycles);
    return CNT_W'(cycles);
  endfunction

endpackage

// File: rtl/mem_responder_tristate.sv
// Tristate bus driver: drives data onto the pad when enabled, high impedance otherwise.
module mem_responder_tristate #(
  parameter int W = 16
) (
  input  logic         en,
  input  logic [W-1:0] data,
  inout  wire  [W-1:0] pad
);

  assign pad = en ? data : {W{1'bz}};

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: latches a request, counts wait states, then
// pulses ready for one cycle and either commits a write or drives read data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              rw,
  input  logic [15:0]       addr,
  inout  wire  [DATA_W-1:0] bus,
  output logic              ready
);

  localparam logic [CNT_W-1:0] WAIT_INIT = wait_load(WAIT_CYCLES);

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic [AW-1:0]      addr_r;
  logic               rw_r;
  logic [DATA_W-1:0]  data_r;
  logic               ready_r;
  logic               oe_r;
  logic [DATA_W-1:0]  mem_r [2**AW];

  logic               latch_s;
  logic               enter_ready_s;
  logic               rw_eff_s;
  logic               wr_s;
  logic [AW-1:0]      wr_addr_s;
  logic [DATA_W-1:0]  wr_data_s;
  logic [DATA_W-1:0]  rd_data_s;
  logic               unused_addr_s;

  assign unused_addr_s = ^addr[15:AW];

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    latch_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_en) begin
          latch_s = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_s = ST_READY;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = WAIT_INIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!mem_en) begin
          state_s = ST_IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_s = ST_READY;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_READY: state_s = ST_HOLD;
      ST_HOLD: begin
        if (!mem_en) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // With zero wait states READY is entered straight from IDLE, so the
  // request fields come from the ports rather than the latches.
  always_comb begin
    enter_ready_s = (state_s == ST_READY) && (state_r != ST_READY);
    rw_eff_s      = latch_s ? rw : rw_r;
    wr_addr_s     = latch_s ? addr[AW-1:0] : addr_r;
    wr_data_s     = latch_s ? bus : data_r;
    wr_s          = enter_ready_s && rw_eff_s;
    rd_data_s     = mem_r[addr_r];
  end

  // State, counter, request latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {AW{1'b0}};
      rw_r    <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      ready_r <= 1'b0;
      oe_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ready_r <= enter_ready_s;
      oe_r    <= enter_ready_s && !rw_eff_s;
      if (latch_s) begin
        addr_r <= addr[AW-1:0];
        rw_r   <= rw;
        data_r <= bus;
      end
    end
  end

  // Storage is deliberately not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  assign ready = ready_r;

  mem_responder_tristate #(.W(DATA_W)) u_bus_drv (
    .en   (oe_r),
    .data (rd_data_s),
    .pad  (bus)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with the default wait
// states and one with zero wait states, checked by a negedge monitor.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int WA = DEF_WAIT_CYCLES;
  localparam int WB = 0;

  typedef struct {
    bit          is_read;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mem_en;
  logic [1:0]  rw;
  logic [1:0]  tb_oe;
  logic [1:0]  rdy;
  logic [15:0] addr    [2];
  logic [15:0] tb_data [2];
  wire  [15:0] bus_a;
  wire  [15:0] bus_b;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  assign bus_a = tb_oe[0] ? tb_data[0] : 16'hzzzz;
  assign bus_b = tb_oe[1] ? tb_data[1] : 16'hzzzz;
  wire z_a = (bus_a === 16'hzzzz);
  wire z_b = (bus_b === 16'hzzzz);

  mem_responder #(.DATA_W(16), .AW(8), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en[0]), .rw(rw[0]),
    .addr(addr[0]), .bus(bus_a), .ready(rdy[0]));

  mem_responder #(.DATA_W(16), .AW(8), .WAIT_CYCLES(WB)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en[1]), .rw(rw[1]),
    .addr(addr[1]), .bus(bus_b), .ready(rdy[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon(input int id, input logic r, input logic isz, input logic [15:0] v);
    exp_t e;
    bit   due;
    due = 1'b0;
    if (id == 0) begin
      if (q_a.size() > 0 && q_a[0].cyc == cyc) begin due = 1'b1; e = q_a.pop_front(); end
    end else begin
      if (q_b.size() > 0 && q_b[0].cyc == cyc) begin due = 1'b1; e = q_b.pop_front(); end
    end
    check(id == 0 ? "ready_a" : "ready_b", 32'(r), 32'(due));
    if (due) begin
      if (e.is_read) check(id == 0 ? "rd_data_a" : "rd_data_b", 32'(v), 32'(e.data));
      else           check(id == 0 ? "wr_bus_z_a" : "wr_bus_z_b", 32'(isz), 32'd1);
    end else if (!tb_oe[id]) begin
      check(id == 0 ? "idle_bus_z_a" : "idle_bus_z_b", 32'(isz), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, rdy[0], z_a, bus_a);
      mon(1, rdy[1], z_b, bus_b);
    end
  end

  task automatic drive(input int id, input logic w, input logic [15:0] a, input logic [15:0] d);
    mem_en[id]  = 1'b1;
    rw[id]      = w;
    addr[id]    = a;
    tb_data[id] = d;
    tb_oe[id]   = w;
    @(posedge clk);
    #1;
    addr[id]    = ~a;
    rw[id]      = ~w;
    tb_data[id] = ~d;
    tb_oe[id]   = 1'b0;
  endtask

  // For reads, d is the data the bench expects on the bus in the ready cycle.
  task automatic req(input int id, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input int hold);
    exp_t e;
    bit   seen;
    @(negedge clk);
    e.is_read = !w;
    e.data    = d;
    e.cyc     = cyc + ((id == 0) ? WA : WB) + 1;
    if (id == 0) q_a.push_back(e);
    else         q_b.push_back(e);
    drive(id, w, a, d);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = rdy[id];
    end
    check("ready_seen", 32'(seen), 32'd1);
    repeat (hold) @(negedge clk);
    mem_en[id] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    mem_en = 2'b00;
    rw     = 2'b00;
    tb_oe  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i]    = 16'h0000;
      tb_data[i] = 16'h0000;
    end
    #1;
    check("rst_ready_a", 32'(rdy[0]), 32'd0);
    check("rst_bus_z_a", 32'(z_a), 32'd1);
    check("rst_state_a", 32'(dut_a.state_r), 32'(ST_IDLE));
    check("rst_cnt_a", 32'(dut_a.cnt_r), 32'd0);
    check("rst_ready_b", 32'(rdy[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write then read back with two wait states.
    req(0, 1'b1, 16'h0012, 16'hBEEF, 0);
    req(0, 1'b0, 16'h0012, 16'hBEEF, 0);
    // Address aliasing on the upper bits.
    req(0, 1'b1, 16'h0105, 16'h1234, 0);
    req(0, 1'b0, 16'h0005, 16'h1234, 0);
    // Abort during WAIT leaves storage untouched.
    req(0, 1'b1, 16'h0020, 16'h5555, 0);
    @(negedge clk);
    drive(0, 1'b1, 16'h0020, 16'hAAAA);
    @(negedge clk);
    mem_en[0] = 1'b0;
    repeat (6) @(negedge clk);
    req(0, 1'b0, 16'h0020, 16'h5555, 0);
    // Holding mem_en after ready must not produce a second pulse.
    req(0, 1'b0, 16'h0012, 16'hBEEF, 5);
    req(0, 1'b0, 16'h0005, 16'h1234, 0);

    // Zero wait states.
    req(1, 1'b1, 16'h00AB, 16'hC0DE, 0);
    req(1, 1'b0, 16'h00AB, 16'hC0DE, 0);
    req(1, 1'b0, 16'h01AB, 16'hC0DE, 3);

    // Reset in the middle of a write.
    req(0, 1'b1, 16'h0030, 16'h3333, 0);
    @(negedge clk);
    drive(0, 1'b1, 16'h0030, 16'h0F0F);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready_a", 32'(rdy[0]), 32'd0);
    check("midrst_bus_z_a", 32'(z_a), 32'd1);
    check("midrst_cnt_a", 32'(dut_a.cnt_r), 32'd0);
    @(negedge clk);
    mem_en[0] = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("post_rst_state_a", 32'(dut_a.state_r), 32'(ST_IDLE));
    req(0, 1'b0, 16'h0030, 16'h3333, 0);

    repeat (4) @(negedge clk);
    check("queue_a_empty", 32'(q_a.size()), 32'd0);
    check("queue_b_empty", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
